// File: rtl/axi_txn_sched_pkg.sv
// axi_txn_sched_pkg: shared types, transaction codes and sizing helper for the scheduler.
package axi_txn_sched_pkg;

    localparam logic [1:0] TXN_WRITE = 2'b01;
    localparam logic [1:0] TXN_READ  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_GAP
    } state_t;

    function automatic int clogb2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

endpackage

// File: rtl/axi_txn_sched_rr_arbiter.sv
// axi_txn_sched_rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module axi_txn_sched_rr_arbiter
    import axi_txn_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = clogb2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    int j;

    // Walk offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_txn_sched.sv
// axi_txn_sched: round-robin scheduler sharing one AXI burst master among NUM_REQ requesters.
module axi_txn_sched
    import axi_txn_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16,
    parameter int GAP_CYCLES    = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                   m_axi_aclk,
    input  logic                   m_axi_aresetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [2*NUM_REQ-1:0]   req_type,
    output logic [NUM_REQ-1:0]     req_grant,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_err,
    output logic                   txn_start,
    output logic [1:0]             txn_type,
    input  logic                   txn_done,
    output logic                   sched_busy,
    output logic [CNT_WIDTH-1:0]   wr_count,
    output logic [CNT_WIDTH-1:0]   rd_count
);

    localparam int IW = clogb2(NUM_REQ);
    localparam int TW = clogb2(START_TIMEOUT);

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d, ptr_q, ptr_d, arb_idx;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d, done_q, done_d, err_q, err_d, arb_grant;
    logic                 start_q, start_d, arb_any;
    logic [1:0]           type_q, type_d, arb_type;
    logic [CNT_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    axi_txn_sched_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign arb_type = req_type[{arb_idx, 1'b0} +: 2];

    // cnt_q times the START wait and the GAP hold; both restart from zero on entry.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        start_d = start_q;
        type_d  = type_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (txn_done && arb_any) begin
                    idx_d = arb_idx;
                    cnt_d = '0;
                    if (arb_type == TXN_WRITE || arb_type == TXN_READ) begin
                        grant_d = arb_grant;
                        start_d = 1'b1;
                        type_d  = arb_type;
                        state_d = S_START;
                    end else begin
                        err_d   = arb_grant;
                        ptr_d   = nxt(arb_idx);
                        state_d = S_GAP;
                    end
                end
            end
            S_START: begin
                if (!txn_done) begin
                    start_d = 1'b0;
                    state_d = S_BUSY;
                end else if (cnt_q == TW'(START_TIMEOUT - 1)) begin
                    start_d = 1'b0;
                    grant_d = '0;
                    err_d   = grant_q;
                    ptr_d   = nxt(idx_q);
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BUSY: begin
                if (txn_done) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    wr_d    = wr_q + CNT_WIDTH'(type_q == TXN_WRITE);
                    rd_d    = rd_q + CNT_WIDTH'(type_q == TXN_READ);
                    ptr_d   = nxt(idx_q);
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == TW'(GAP_CYCLES - 1)) state_d = S_IDLE;
                else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            type_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            type_q  <= type_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    assign req_grant  = grant_q;
    assign req_done   = done_q;
    assign req_err    = err_q;
    assign txn_start  = start_q;
    assign txn_type   = type_q;
    assign sched_busy = (state_q != S_IDLE);
    assign wr_count   = wr_q;
    assign rd_count   = rd_q;

endmodule

// File: tb/tb_axi_txn_sched.sv
// tb_axi_txn_sched: directed stimulus with a burst-master model and a transaction-level reference.
module tb_axi_txn_sched;

    localparam int N    = 4;
    localparam int TOUT = 16;
    localparam int GAP  = 2;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [2*N-1:0] req_type = '0;
    logic          txn_done = 1'b1;
    logic [N-1:0]  req_grant, req_done, req_err;
    logic          txn_start, sched_busy;
    logic [1:0]    txn_type;
    logic [CW-1:0] wr_count, rd_count;

    int total = 0;
    int bad = 0;
    int hang = 0;
    int burst = 3;

    always #5 clk = ~clk;

    axi_txn_sched #(
        .NUM_REQ(N), .START_TIMEOUT(TOUT), .GAP_CYCLES(GAP), .CNT_WIDTH(CW)
    ) dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .req_valid     (req_valid),
        .req_type      (req_type),
        .req_grant     (req_grant),
        .req_done      (req_done),
        .req_err       (req_err),
        .txn_start     (txn_start),
        .txn_type      (txn_type),
        .txn_done      (txn_done),
        .sched_busy    (sched_busy),
        .wr_count      (wr_count),
        .rd_count      (rd_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Burst master: goes busy 4 cycles into a start level, stays busy for 'burst' cycles.
    initial begin
        int dly, left;
        dly = 0;
        left = 0;
        forever begin
            @(posedge clk);
            #1;
            if (hang != 0) dly = 0;
            else if (left > 0) begin
                left--;
                if (left == 0) txn_done = 1'b1;
            end else if (txn_start) begin
                dly++;
                if (dly == 4) begin
                    txn_done = 1'b0;
                    left = burst;
                    dly = 0;
                end
            end else dly = 0;
        end
    end

    // Reference: one served transaction at a time, phases idle/start/busy/gap.
    int ph, age, m_idx, m_ptr, gap_left, m_pick, m_t, e_wr, e_rd;
    logic [N-1:0] e_grant, e_done, e_err;
    logic e_start;
    logic [1:0] e_type;

    always_comb begin
        m_pick = -1;
        m_t = 0;
        for (int k = 0; k < N; k++)
            if (m_pick < 0 && req_valid[(m_ptr + k) % N]) m_pick = (m_ptr + k) % N;
        if (m_pick >= 0) m_t = int'(req_type[2*m_pick +: 2]);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= 0; age <= 0; m_idx <= 0; m_ptr <= 0; gap_left <= 0;
            e_grant <= '0; e_done <= '0; e_err <= '0; e_start <= 1'b0; e_type <= '0;
            e_wr <= 0; e_rd <= 0;
        end else begin
            e_done <= '0;
            e_err <= '0;
            if (ph == 0) begin
                if (txn_done && m_pick >= 0) begin
                    m_idx <= m_pick;
                    if (m_t == 1 || m_t == 2) begin
                        e_grant <= N'(1) << m_pick;
                        e_start <= 1'b1;
                        e_type <= 2'(m_t);
                        ph <= 1;
                        age <= 1;
                    end else begin
                        e_err <= N'(1) << m_pick;
                        m_ptr <= (m_pick + 1) % N;
                        ph <= 3;
                        gap_left <= GAP;
                    end
                end
            end else if (ph == 1) begin
                if (!txn_done) begin
                    e_start <= 1'b0;
                    ph <= 2;
                end else if (age == TOUT) begin
                    e_start <= 1'b0;
                    e_grant <= '0;
                    e_err <= N'(1) << m_idx;
                    m_ptr <= (m_idx + 1) % N;
                    ph <= 3;
                    gap_left <= GAP;
                end else age <= age + 1;
            end else if (ph == 2) begin
                if (txn_done) begin
                    e_done <= N'(1) << m_idx;
                    e_grant <= '0;
                    if (e_type == 2'b01) e_wr <= (e_wr + 1) % (1 << CW);
                    else e_rd <= (e_rd + 1) % (1 << CW);
                    m_ptr <= (m_idx + 1) % N;
                    ph <= 3;
                    gap_left <= GAP;
                end
            end else begin
                if (gap_left == 1) ph <= 0;
                else gap_left <= gap_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_grant", 32'(req_grant), 32'(e_grant));
        chk("m_done", 32'(req_done), 32'(e_done));
        chk("m_err", 32'(req_err), 32'(e_err));
        chk("m_start", 32'(txn_start), 32'(e_start));
        chk("m_type", 32'(txn_type), 32'(e_type));
        chk("m_busy", 32'(sched_busy), 32'(ph != 0));
        chk("m_wr", 32'(wr_count), 32'(e_wr));
        chk("m_rd", 32'(rd_count), 32'(e_rd));
    end

    task automatic wait_resp(output int n);
        n = 0;
        while (req_done == '0 && req_err == '0 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (req_grant == '0 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_grant", 32'(req_grant), 0);
        chk("rst_start", 32'(txn_start), 0);
        chk("rst_busy", 32'(sched_busy), 0);
        chk("rst_type", 32'(txn_type), 0);
        chk("rst_wr", 32'(wr_count), 0);
        chk("rst_rd", 32'(rd_count), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // All four requesters, mixed types: order 0,1,2,3,0
        req_type = 8'b10_01_10_01;
        req_valid = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            wait_resp(n);
            chk("a_resp_wait", 32'(n < 300), 1);
            chk("a_order", 32'(oh_idx(req_done)), 32'(s % N));
            if (s < 4) begin
                n = 0;
                while (!txn_start && n < 50) begin
                    tick();
                    n++;
                end
                chk("a_gap", 32'(n), 3);
            end
        end
        chk("a_wr", 32'(wr_count), 3);
        chk("a_rd", 32'(rd_count), 2);
        req_valid = '0;
        repeat (4) tick();

        // Single write from requester 2
        do_reset();
        req_type = '0;
        req_type[5:4] = 2'b01;
        req_valid = 4'b0100;
        tick();
        chk("b_start", 32'(txn_start), 1);
        chk("b_type", 32'(txn_type), 1);
        chk("b_grant", 32'(req_grant), 4);
        wait_resp(n);
        chk("b_done", 32'(req_done), 4);
        chk("b_wr", 32'(wr_count), 1);
        chk("b_rd", 32'(rd_count), 0);
        req_valid = '0;
        repeat (4) tick();

        // Bad type on requester 1, then requester 2 served
        req_type[3:2] = 2'b11;
        req_valid = 4'b0110;
        tick();
        chk("c_err", 32'(req_err), 2);
        chk("c_grant0", 32'(req_grant), 0);
        chk("c_start", 32'(txn_start), 0);
        req_valid = 4'b0100;
        wait_grant(n);
        chk("c_grant", 32'(req_grant), 4);
        wait_resp(n);
        chk("c_done", 32'(req_done), 4);
        req_valid = '0;
        repeat (4) tick();

        // Start timeout: master never goes busy
        hang = 1;
        req_type[7:6] = 2'b10;
        req_valid = 4'b1000;
        tick();
        n = 0;
        while (txn_start && n < 100) begin
            n++;
            tick();
        end
        chk("d_len", 32'(n), 32'(TOUT));
        chk("d_err", 32'(req_err), 8);
        chk("d_grant", 32'(req_grant), 0);
        req_valid = '0;
        tick();
        chk("d_gap_busy", 32'(sched_busy), 1);
        tick();
        chk("d_idle", 32'(sched_busy), 0);
        chk("d_rd", 32'(rd_count), 0);
        hang = 0;
        repeat (2) tick();

        // Reset during BUSY with a long in-flight burst
        burst = 20;
        req_type[1:0] = 2'b01;
        req_valid = 4'b0001;
        wait_grant(n);
        n = 0;
        while (txn_done && n < 100) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("e_busy", 32'(sched_busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("e_rst_grant", 32'(req_grant), 0);
        chk("e_rst_start", 32'(txn_start), 0);
        chk("e_rst_busy", 32'(sched_busy), 0);
        chk("e_rst_pulse", 32'({req_done, req_err}), 0);
        chk("e_rst_type", 32'(txn_type), 0);
        chk("e_rst_wr", 32'(wr_count), 0);
        @(posedge clk);
        #2;
        req_type[7:6] = 2'b01;
        req_valid = 4'b1001;
        rst_n = 1'b1;
        chk("e_still_busy", 32'(txn_done), 0);
        n = 0;
        while (!txn_done && n < 100) begin
            chk("e_nogrant", 32'(req_grant), 0);
            tick();
            n++;
        end
        chk("e_drain", 32'(n < 100), 1);
        wait_grant(n);
        chk("e_grant", 32'(req_grant), 1);
        req_valid = 4'b0001;
        wait_resp(n);
        chk("e_done", 32'(req_done), 1);
        req_valid = '0;
        burst = 3;
        repeat (4) tick();

        // 17 reads with 4-bit counters: rd_count wraps to 1
        do_reset();
        burst = 1;
        req_type = '0;
        req_type[3:2] = 2'b10;
        for (int s = 0; s < 17; s++) begin
            req_valid = 4'b0010;
            wait_resp(n);
            chk("f_done", 32'(req_done), 2);
            req_valid = '0;
            repeat (3) tick();
        end
        chk("f_rd", 32'(rd_count), 1);
        chk("f_wr", 32'(wr_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
